// File: rtl/serv_rf_pkg.sv
// serv_rf_pkg: register map and helpers shared by the
// serv register-file RAM bridge.
package serv_rf_pkg;

  localparam int NREGS    = 36;
  localparam int REG_AW   = 6;
  localparam int CSR_BASE = 32;

  typedef enum logic [REG_AW-1:0] {
    CSR_MSCRATCH = 6'd32,
    CSR_MTVEC    = 6'd33,
    CSR_MEPC     = 6'd34,
    CSR_MTVAL    = 6'd35
  } csr_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_DRAIN
  } rd_state_e;

  function automatic int rf_depth(input int width);
    return NREGS * 32 / width;
  endfunction

  function automatic int rf_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/serv_rf_shreg.sv
// serv_rf_shreg: width-bit buffer, parallel load or
// W-bit shift towards the LSB; exposes the low ow bits.
module serv_rf_shreg #(
  parameter int width = 2,
  parameter int W     = 1,
  parameter int ow    = width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [width-1:0] d,
  input  logic [W-1:0]     sin,
  output logic [ow-1:0]    q
);

  logic [width-1:0] r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (load) begin
      r <= d;
    end else if (shift) begin
      r <= {sin, r[width-1:W]};
    end
  end

  assign q = r[ow-1:0];

endmodule

// File: rtl/serv_rf_ram_bridge.sv
// serv_rf_ram_bridge: bit-serial register-file ports
// onto a width-bit synchronous RAM.
module serv_rf_ram_bridge
  import serv_rf_pkg::*;
#(
  parameter int width = 2,
  parameter int W     = 1,
  parameter int depth = rf_depth(width),
  parameter int aw    = rf_aw(depth)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rreq,
  output logic              o_ready,
  input  logic [REG_AW-1:0] i_rreg0,
  input  logic [REG_AW-1:0] i_rreg1,
  output logic [W-1:0]      o_rdata0,
  output logic [W-1:0]      o_rdata1,
  input  logic [REG_AW-1:0] i_wreg0,
  input  logic [REG_AW-1:0] i_wreg1,
  input  logic              i_wen0,
  input  logic              i_wen1,
  input  logic [W-1:0]      i_wdata0,
  input  logic [W-1:0]      i_wdata1,
  output logic [aw-1:0]     o_raddr,
  output logic              o_ren,
  input  logic [width-1:0]  i_rdata,
  output logic [aw-1:0]     o_waddr,
  output logic [width-1:0]  o_wdata,
  output logic              o_wen
);

  localparam int R        = width / W;
  localparam int N        = 32 / width;
  localparam int LR       = $clog2(R);
  localparam int LN       = $clog2(N);
  localparam int LW       = $clog2(W);
  localparam int LWD      = $clog2(width);
  localparam int LAST_ISS = (N - 1) * R + 1;
  localparam int RC_END   = 32 / W + 2;
  localparam int RCW      = $clog2(RC_END + 1);

  function automatic logic [aw-1:0] mk_addr(
    input logic [REG_AW-1:0] r,
    input logic [5:0]        k
  );
    return (aw'(r) << LN) | aw'(k);
  endfunction

  rd_state_e         rstate, rstate_n;
  logic [RCW-1:0]    rcnt, rcnt_n, nt;
  logic [REG_AW-1:0] rreg0, rreg1;
  logic              ren_n, ready_n;
  logic [aw-1:0]     raddr_n;
  logic [width-1:0]  hold0;
  logic              hold_ld, rd_ld;

  assign nt = rcnt + RCW'(1);

  always_comb begin
    rstate_n = rstate;
    rcnt_n   = rcnt;
    ren_n    = 1'b0;
    raddr_n  = o_raddr;
    ready_n  = 1'b0;
    unique case (rstate)
      RD_IDLE: begin
        if (i_rreq) begin
          rstate_n = RD_FETCH;
          rcnt_n   = '0;
          ren_n    = 1'b1;
          raddr_n  = mk_addr(i_rreg0, '0);
        end
      end
      RD_FETCH: begin
        rcnt_n  = nt;
        ready_n = (rcnt == RCW'(1));
        if (rcnt == RCW'(LAST_ISS)) begin
          rstate_n = RD_DRAIN;
        end else if (nt[LR-1:0] == '0) begin
          ren_n   = 1'b1;
          raddr_n = mk_addr(rreg0, 6'(nt >> LR));
        end else if (nt[LR-1:0] == LR'(1)) begin
          ren_n   = 1'b1;
          raddr_n = mk_addr(rreg1, 6'(nt >> LR));
        end
      end
      RD_DRAIN: begin
        rcnt_n = nt;
        if (rcnt == RCW'(RC_END)) begin
          rstate_n = RD_IDLE;
        end
      end
      default: rstate_n = RD_IDLE;
    endcase
  end

  // port 0 word is parked one cycle so both ports stream in step
  assign hold_ld = (rstate != RD_IDLE)
                && (rcnt[LR-1:0] == LR'(1))
                && (rcnt <= RCW'(LAST_ISS));
  assign rd_ld   = (rstate != RD_IDLE)
                && (rcnt >= RCW'(2))
                && (((rcnt - RCW'(2)) & RCW'(R - 1)) == '0)
                && (rcnt <= RCW'(LAST_ISS + 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rstate  <= RD_IDLE;
      rcnt    <= '0;
      rreg0   <= '0;
      rreg1   <= '0;
      o_ren   <= 1'b0;
      o_raddr <= '0;
      o_ready <= 1'b0;
      hold0   <= '0;
    end else begin
      rstate  <= rstate_n;
      rcnt    <= rcnt_n;
      o_ren   <= ren_n;
      o_raddr <= raddr_n;
      o_ready <= ready_n;
      if (rstate == RD_IDLE && i_rreq) begin
        rreg0 <= i_rreg0;
        rreg1 <= i_rreg1;
      end
      if (hold_ld) begin
        hold0 <= i_rdata;
      end
    end
  end

  serv_rf_shreg #(.width(width), .W(W), .ow(W)) u_rd0 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (rd_ld),
    .shift (1'b1),
    .d     (hold0),
    .sin   ('0),
    .q     (o_rdata0)
  );

  serv_rf_shreg #(.width(width), .W(W), .ow(W)) u_rd1 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (rd_ld),
    .shift (1'b1),
    .d     (i_rdata),
    .sin   ('0),
    .q     (o_rdata1)
  );

  logic [4:0]       wcnt, wofs;
  logic [5:0]       wword;
  logic             wen_any, wdone;
  logic             seen0, seen1, p0, p1, pend1;
  logic [aw-1:0]    paddr1;
  logic [width-1:0] acc0_q, acc1_q, acc0_nx;

  assign wen_any = i_wen0 | i_wen1;
  assign wofs    = (wcnt & 5'(width - 1)) >> LW;
  assign wdone   = wen_any && (wofs == 5'(R - 1));
  assign wword   = 6'(wcnt >> LWD);
  assign p0      = seen0 | i_wen0;
  assign p1      = seen1 | i_wen1;
  assign acc0_nx = i_wen0 ? {i_wdata0, acc0_q[width-1:W]}
                          : acc0_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt    <= '0;
      seen0   <= 1'b0;
      seen1   <= 1'b0;
      pend1   <= 1'b0;
      paddr1  <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      if (wen_any) begin
        wcnt <= wcnt + 5'(W);
      end
      seen0 <= !wdone && p0;
      seen1 <= !wdone && p1;
      if (wdone) begin
        o_wen  <= p0;
        pend1  <= p1;
        paddr1 <= mk_addr(i_wreg1, wword);
        if (p0) begin
          o_waddr <= mk_addr(i_wreg0, wword);
          o_wdata <= acc0_nx;
        end
      end else if (pend1) begin
        o_wen   <= 1'b1;
        pend1   <= 1'b0;
        o_waddr <= paddr1;
        o_wdata <= acc1_q;
      end else begin
        o_wen <= 1'b0;
      end
    end
  end

  serv_rf_shreg #(.width(width), .W(W)) u_acc0 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (1'b0),
    .shift (i_wen0),
    .d     ('0),
    .sin   (i_wdata0),
    .q     (acc0_q)
  );

  serv_rf_shreg #(.width(width), .W(W)) u_acc1 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (1'b0),
    .shift (i_wen1),
    .d     ('0),
    .sin   (i_wdata1),
    .q     (acc1_q)
  );

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// tb_serv_rf_ram_bridge: directed bench for the serial
// register-file RAM bridge, width=2 W=1.
module tb_serv_rf_ram_bridge;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          rreq, ready;
  logic [5:0]    rreg0, rreg1, wreg0, wreg1;
  logic [0:0]    rdata0, rdata1, wdata0, wdata1;
  logic          wen0, wen1;
  logic [AW-1:0] raddr, waddr;
  logic          ren, ram_wen;
  logic [1:0]    ram_rdata, ram_wdata;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [1:0]    pl_data;
  logic [1:0]    mem [0:1023];

  int checks = 0;
  int errors = 0;

  serv_rf_ram_bridge #(.width(2), .W(1)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_rreq   (rreq),
    .o_ready  (ready),
    .i_rreg0  (rreg0),
    .i_rreg1  (rreg1),
    .o_rdata0 (rdata0),
    .o_rdata1 (rdata1),
    .i_wreg0  (wreg0),
    .i_wreg1  (wreg1),
    .i_wen0   (wen0),
    .i_wen1   (wen1),
    .i_wdata0 (wdata0),
    .i_wdata1 (wdata1),
    .o_raddr  (raddr),
    .o_ren    (ren),
    .i_rdata  (ram_rdata),
    .o_waddr  (waddr),
    .o_wdata  (ram_wdata),
    .o_wen    (ram_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ren) ram_rdata <= mem[raddr];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wen) mem[waddr] <= ram_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] r,
                         input logic [31:0] v);
    for (int k = 0; k < 16; k++) begin
      pl_en   = 1'b1;
      pl_addr = {r, 4'(k)};
      pl_data = v[2*k +: 2];
      step();
    end
    pl_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] r0,
                         input logic [5:0] r1,
                         input logic [31:0] e0,
                         input logic [31:0] e1,
                         input bit poke);
    logic [31:0] d0, d1;
    int nren, nrdy;
    d0 = '0;
    d1 = '0;
    nren = 0;
    nrdy = 0;
    rreq = 1'b1;
    rreg0 = r0;
    rreg1 = r1;
    step();
    rreq = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ren) nren++;
      if (ready) nrdy++;
      if (c == 1) begin
        chk("rd_c1_ren", ren, 1);
        chk("rd_c1_addr", raddr, {r0, 4'h0});
        rreg0 = 6'h3f;
        rreg1 = 6'h3f;
      end
      if (c == 2) begin
        chk("rd_c2", {ren, raddr}, {1'b1, r1, 4'h0});
      end
      if (c == 3) chk("rd_c3_ready", ready, 1);
      if (c >= 4 && c <= 35) begin
        d0[c-4] = rdata0[0];
        d1[c-4] = rdata1[0];
      end
      rreq = poke && (c == 1);
      if (c < 40) step();
    end
    chk("rd_ren_count", nren, 32);
    chk("rd_ready_count", nrdy, 1);
    chk("rd_data0", d0, e0);
    chk("rd_data1", d1, e1);
  endtask

  task automatic do_write(input bit en0,
                          input logic [5:0] r0,
                          input logic [31:0] v0,
                          input bit en1,
                          input logic [5:0] r1,
                          input logic [31:0] v1,
                          input string tag);
    int npulse, k;
    npulse = 0;
    wreg0 = r0;
    wreg1 = r1;
    for (int m = 0; m < 34; m++) begin
      if (m < 32) begin
        wen0 = en0;
        wen1 = en1;
        wdata0 = v0[m];
        wdata1 = v1[m];
      end else begin
        wen0 = 1'b0;
        wen1 = 1'b0;
      end
      step();
      if (ram_wen) npulse++;
      if (m % 2 == 1 && m < 32) begin
        k = (m - 1) / 2;
        if (en0)
          chk($sformatf("%s_p0_w%0d", tag, k),
              {ram_wen, waddr, ram_wdata},
              {1'b1, r0, 4'(k), v0[2*k +: 2]});
        else
          chk($sformatf("%s_p0_idle%0d", tag, k),
              ram_wen, 0);
      end else if (m % 2 == 0 && m >= 2) begin
        k = (m - 2) / 2;
        if (en1)
          chk($sformatf("%s_p1_w%0d", tag, k),
              {ram_wen, waddr, ram_wdata},
              {1'b1, r1, 4'(k), v1[2*k +: 2]});
        else
          chk($sformatf("%s_p1_idle%0d", tag, k),
              ram_wen, 0);
      end else begin
        chk($sformatf("%s_quiet%0d", tag, m), ram_wen, 0);
      end
    end
    chk({tag, "_pulses"}, npulse,
        16 * (int'(en0) + int'(en1)));
  endtask

  initial begin
    int nbad;
    rst_n = 1'b0;
    rreq = 1'b0;
    rreg0 = '0;
    rreg1 = '0;
    wreg0 = '0;
    wreg1 = '0;
    wen0 = 1'b0;
    wen1 = 1'b0;
    wdata0 = '0;
    wdata1 = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;

    step();
    chk("reset_outs",
        {ready, ren, ram_wen, raddr, waddr,
         ram_wdata, rdata0, rdata1}, 0);
    step();
    rst_n = 1'b1;

    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ready || ren || ram_wen) nbad++;
      if (raddr != 0 || waddr != 0 || ram_wdata != 0) nbad++;
      if (rdata0 != 0 || rdata1 != 0) nbad++;
    end
    chk("idle_quiet", nbad, 0);

    preload(6'd5, 32'hDEADBEEF);
    preload(6'd34, 32'h12345678);
    do_read(6'd5, 6'd34, 32'hDEADBEEF, 32'h12345678, 0);

    do_write(1, 6'd7, 32'hA5A50F0F,
             1, 6'd35, 32'h00000001, "w_both");
    do_read(6'd7, 6'd35, 32'hA5A50F0F, 32'h00000001, 0);

    do_write(0, 6'd5, 32'h0,
             1, 6'd12, 32'h0F0F1234, "w_p1");
    do_read(6'd12, 6'd5, 32'h0F0F1234, 32'hDEADBEEF, 0);

    do_read(6'd34, 6'd7, 32'h12345678, 32'hA5A50F0F, 1);

    wreg0 = 6'd3;
    wreg1 = 6'd0;
    for (int j = 0; j < 10; j++) begin
      wen0 = 1'b1;
      wdata0 = 1'(j);
      step();
    end
    rst_n = 1'b0;
    wen0 = 1'b0;
    #1;
    chk("midrst_outs",
        {ready, ren, ram_wen, raddr, waddr,
         ram_wdata, rdata0, rdata1}, 0);
    step();
    step();
    rst_n = 1'b1;
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ram_wen) nbad++;
    end
    chk("midrst_no_wen", nbad, 0);

    do_write(1, 6'd9, 32'h13579BDF,
             0, 6'd0, 32'h0, "w_after_rst");
    do_read(6'd9, 6'd35, 32'h13579BDF, 32'h00000001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
